// File: rtl/sram_resp_pkg.sv
// Shared constants, region-select type and byte-lane merge helper for sram_resp.
package sram_resp_pkg;

    localparam logic [15:0] MMIO_HI_DEFAULT = 16'hBFAF;

    localparam logic [15:0] OFF_LED     = 16'h0000;
    localparam logic [15:0] OFF_TIMER   = 16'h0004;
    localparam logic [15:0] OFF_SCRATCH = 16'h0008;

    localparam int LANES  = 4;
    localparam int LANE_W = 8;

    typedef enum logic [2:0] {
        SEL_RAM,
        SEL_LED,
        SEL_TIMER,
        SEL_SCRATCH,
        SEL_NONE
    } sel_e;

    // Written lanes come from wdata, the rest keep the old value.
    function automatic logic [31:0] lane_merge(input logic [31:0] old_val,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  wen);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < LANES; i++) begin
            if (wen[i]) res[LANE_W*i +: LANE_W] = wdata[LANE_W*i +: LANE_W];
        end
        return res;
    endfunction

endpackage

// File: rtl/sram_resp_if.sv
// Request/response bus between the SRAM-style master and sram_resp.
interface sram_resp_if;

    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic [15:0] led;

    modport master (
        output sram_en, sram_wen, sram_addr, sram_wdata,
        input  sram_rdata, led
    );

    modport slave (
        input  sram_en, sram_wen, sram_addr, sram_wdata,
        output sram_rdata, led
    );

endinterface

// File: rtl/sram_bank.sv
// Byte-enable RAM array: synchronous per-lane write, combinational read, no reset.
module sram_bank
    import sram_resp_pkg::*;
#(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic [3:0]        we,
    input  logic [ADDR_W-1:0] idx,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0] mem [DEPTH];

    // Per-lane write of the addressed word.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (we[i]) mem[idx][LANE_W*i +: LANE_W] <= wdata[LANE_W*i +: LANE_W];
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/sram_resp.sv
// SRAM responder: address decode, RAM bank, MMIO registers (LED/TIMER/SCRATCH)
// and the one-cycle registered read path.
module sram_resp
    import sram_resp_pkg::*;
#(
    parameter int unsigned ADDR_W  = 12,
    parameter logic [15:0] MMIO_HI = MMIO_HI_DEFAULT
) (
    input  logic      clk,
    input  logic      rst,
    sram_resp_if.slave bus
);

    logic [31:0] rdata_q, rdata_d;
    logic [15:0] led_q, led_d;
    logic [31:0] timer_q, timer_d;
    logic [31:0] scratch_q, scratch_d;

    sel_e              sel;
    logic              rd_acc;
    logic              wr_acc;
    logic [3:0]        ram_we;
    logic [ADDR_W-1:0] ram_idx;
    logic [31:0]       ram_rdata;

    // Region decode and access classification; with sram_en low nothing is accepted.
    always_comb begin
        sel    = SEL_RAM;
        rd_acc = bus.sram_en && (bus.sram_wen == 4'b0000);
        wr_acc = bus.sram_en && (bus.sram_wen != 4'b0000);
        if (bus.sram_addr[31:16] == MMIO_HI) begin
            case (bus.sram_addr[15:0])
                OFF_LED:     sel = SEL_LED;
                OFF_TIMER:   sel = SEL_TIMER;
                OFF_SCRATCH: sel = SEL_SCRATCH;
                default:     sel = SEL_NONE;
            endcase
        end
    end

    // Upper address bits above the bank index are dropped, giving wrap-around.
    assign ram_idx = bus.sram_addr[ADDR_W+1:2];
    assign ram_we  = (wr_acc && (sel == SEL_RAM)) ? bus.sram_wen : 4'b0000;

    sram_bank #(
        .ADDR_W(ADDR_W)
    ) u_bank (
        .clk   (clk),
        .we    (ram_we),
        .idx   (ram_idx),
        .wdata (bus.sram_wdata),
        .rdata (ram_rdata)
    );

    // Next-state for MMIO registers and the read register; TIMER writes override the increment.
    always_comb begin
        led_d     = led_q;
        timer_d   = timer_q + 32'd1;
        scratch_d = scratch_q;
        rdata_d   = rdata_q;

        if (wr_acc) begin
            case (sel)
                SEL_LED: begin
                    led_d[7:0]  = bus.sram_wen[0] ? bus.sram_wdata[7:0]  : led_q[7:0];
                    led_d[15:8] = bus.sram_wen[1] ? bus.sram_wdata[15:8] : led_q[15:8];
                end
                SEL_TIMER:   timer_d   = lane_merge(timer_q, bus.sram_wdata, bus.sram_wen);
                SEL_SCRATCH: scratch_d = lane_merge(scratch_q, bus.sram_wdata, bus.sram_wen);
                default: ;
            endcase
        end

        // TIMER reads return the pre-edge value, i.e. timer_q.
        if (rd_acc) begin
            case (sel)
                SEL_RAM:     rdata_d = ram_rdata;
                SEL_LED:     rdata_d = {16'h0000, led_q};
                SEL_TIMER:   rdata_d = timer_q;
                SEL_SCRATCH: rdata_d = scratch_q;
                default:     rdata_d = 32'h0000_0000;
            endcase
        end
    end

    // Register update with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q   <= 32'h0000_0000;
            led_q     <= 16'h0000;
            timer_q   <= 32'h0000_0000;
            scratch_q <= 32'h0000_0000;
        end else begin
            rdata_q   <= rdata_d;
            led_q     <= led_d;
            timer_q   <= timer_d;
            scratch_q <= scratch_d;
        end
    end

    assign bus.sram_rdata = rdata_q;
    assign bus.led        = led_q;

endmodule

// File: tb/tb_sram_resp.sv
// Directed bench for sram_resp: vector table plus TIMER and reset sequences.
module tb_sram_resp;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    sram_resp_if bus ();

    sram_resp dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic [15:0] exp_led;
    } vec_t;

    localparam int NV = 28;
    vec_t vecs [NV];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic drive(input logic en, input logic [3:0] wen,
                         input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        bus.sram_en    = en;
        bus.sram_wen   = wen;
        bus.sram_addr  = addr;
        bus.sram_wdata = wdata;
    endtask

    // One accepted cycle; returns #1 after the active edge.
    task automatic access(input logic en, input logic [3:0] wen,
                          input logic [31:0] addr, input logic [31:0] wdata);
        drive(en, wen, addr, wdata);
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;

        vecs[0]  = '{1'b1, 4'hF, 32'h0000_0010, 32'h1234_5678, 32'h0000_0000, 16'h0000};
        vecs[1]  = '{1'b1, 4'h0, 32'h0000_0010, 32'h0000_0000, 32'h1234_5678, 16'h0000};
        vecs[2]  = '{1'b1, 4'h2, 32'h0000_0010, 32'hAABB_CCDD, 32'h1234_5678, 16'h0000};
        vecs[3]  = '{1'b1, 4'h0, 32'h0000_0010, 32'h0000_0000, 32'h1234_CC78, 16'h0000};
        vecs[4]  = '{1'b1, 4'h0, 32'h0000_0013, 32'h0000_0000, 32'h1234_CC78, 16'h0000};
        vecs[5]  = '{1'b1, 4'hF, 32'h0000_4000, 32'h0000_0055, 32'h1234_CC78, 16'h0000};
        vecs[6]  = '{1'b1, 4'h0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0055, 16'h0000};
        vecs[7]  = '{1'b1, 4'hF, 32'h0000_0014, 32'hCAFE_F00D, 32'h0000_0055, 16'h0000};
        vecs[8]  = '{1'b1, 4'h0, 32'h0000_0014, 32'h0000_0000, 32'hCAFE_F00D, 16'h0000};
        vecs[9]  = '{1'b1, 4'h0, 32'h0000_0010, 32'h0000_0000, 32'h1234_CC78, 16'h0000};
        vecs[10] = '{1'b1, 4'h0, 32'hBFAE_0000, 32'h0000_0000, 32'h0000_0055, 16'h0000};
        vecs[11] = '{1'b1, 4'hF, 32'hBFAF_0000, 32'hFFFF_A5A5, 32'h0000_0055, 16'hA5A5};
        vecs[12] = '{1'b1, 4'h0, 32'hBFAF_0000, 32'h0000_0000, 32'h0000_A5A5, 16'hA5A5};
        vecs[13] = '{1'b1, 4'h0, 32'hBFAF_00F0, 32'h0000_0000, 32'h0000_0000, 16'hA5A5};
        vecs[14] = '{1'b1, 4'hF, 32'hBFAF_00F0, 32'hFFFF_FFFF, 32'h0000_0000, 16'hA5A5};
        vecs[15] = '{1'b1, 4'h0, 32'hBFAF_00F0, 32'h0000_0000, 32'h0000_0000, 16'hA5A5};
        vecs[16] = '{1'b0, 4'hF, 32'hBFAF_0000, 32'h0000_0000, 32'h0000_0000, 16'hA5A5};
        vecs[17] = '{1'b0, 4'h0, 32'h0000_0010, 32'h0000_0000, 32'h0000_0000, 16'hA5A5};
        vecs[18] = '{1'b1, 4'h1, 32'hBFAF_0000, 32'h0000_003C, 32'h0000_0000, 16'hA53C};
        vecs[19] = '{1'b1, 4'h0, 32'hBFAF_0000, 32'h0000_0000, 32'h0000_A53C, 16'hA53C};
        vecs[20] = '{1'b1, 4'hF, 32'hBFAF_0008, 32'hDEAD_BEEF, 32'h0000_A53C, 16'hA53C};
        vecs[21] = '{1'b1, 4'h4, 32'hBFAF_0008, 32'h0011_0000, 32'h0000_A53C, 16'hA53C};
        vecs[22] = '{1'b1, 4'h0, 32'hBFAF_0008, 32'h0000_0000, 32'hDE11_BEEF, 16'hA53C};
        vecs[23] = '{1'b1, 4'h4, 32'hBFAF_0008, 32'h00AD_0000, 32'hDE11_BEEF, 16'hA53C};
        vecs[24] = '{1'b1, 4'h0, 32'hBFAF_0008, 32'h0000_0000, 32'hDEAD_BEEF, 16'hA53C};
        vecs[25] = '{1'b0, 4'h0, 32'hBFAF_0000, 32'h0000_0000, 32'hDEAD_BEEF, 16'hA53C};
        vecs[26] = '{1'b1, 4'hF, 32'hBFAF_0010, 32'h0000_0000, 32'hDEAD_BEEF, 16'hA53C};
        vecs[27] = '{1'b1, 4'h0, 32'h0000_0010, 32'h0000_0000, 32'h1234_CC78, 16'hA53C};

        rst            = 1'b1;
        bus.sram_en    = 1'b0;
        bus.sram_wen   = 4'h0;
        bus.sram_addr  = 32'h0;
        bus.sram_wdata = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        check32("reset_rdata", bus.sram_rdata, 32'h0);
        check32("reset_led", {16'h0, bus.led}, 32'h0);

        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            access(vecs[i].en, vecs[i].wen, vecs[i].addr, vecs[i].wdata);
            check32($sformatf("vec%0d_rdata", i), bus.sram_rdata, vecs[i].exp_rdata);
            check32($sformatf("vec%0d_led", i), {16'h0, bus.led}, {16'h0, vecs[i].exp_led});
        end

        // TIMER: load, count, wrap, partial-lane write overriding the increment.
        access(1'b1, 4'hF, 32'hBFAF_0004, 32'hFFFF_FFFE);
        access(1'b0, 4'h0, 32'h0, 32'h0);
        access(1'b1, 4'h0, 32'hBFAF_0004, 32'h0);
        check32("timer_max", bus.sram_rdata, 32'hFFFF_FFFF);
        access(1'b1, 4'h0, 32'hBFAF_0004, 32'h0);
        check32("timer_wrap", bus.sram_rdata, 32'h0000_0000);
        access(1'b1, 4'h1, 32'hBFAF_0004, 32'h0000_00AA);
        check32("timer_wr_hold_rdata", bus.sram_rdata, 32'h0000_0000);
        access(1'b1, 4'h0, 32'hBFAF_0004, 32'h0);
        check32("timer_lane_load", bus.sram_rdata, 32'h0000_00AA);
        access(1'b0, 4'h0, 32'h0, 32'h0);
        access(1'b0, 4'h0, 32'h0, 32'h0);
        access(1'b1, 4'h0, 32'hBFAF_0004, 32'h0);
        check32("timer_idle_count", bus.sram_rdata, 32'h0000_00AD);

        // Reset mid-idle after a SCRATCH read.
        access(1'b1, 4'h0, 32'hBFAF_0008, 32'h0);
        check32("scratch_pre_reset", bus.sram_rdata, 32'hDEAD_BEEF);
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        rst = 1'b1;
        #1;
        check32("async_rst_rdata", bus.sram_rdata, 32'h0);
        check32("async_rst_led", {16'h0, bus.led}, 32'h0);
        @(posedge clk);
        drive(1'b1, 4'hF, 32'hBFAF_0000, 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        check32("write_in_reset_led", {16'h0, bus.led}, 32'h0);
        drive(1'b1, 4'h0, 32'hBFAF_0008, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check32("scratch_post_reset", bus.sram_rdata, 32'h0);
        access(1'b1, 4'h0, 32'hBFAF_0000, 32'h0);
        check32("led_read_post_reset", bus.sram_rdata, 32'h0);
        check32("led_post_reset", {16'h0, bus.led}, 32'h0);
        access(1'b1, 4'h0, 32'hBFAF_0004, 32'h0);
        check32("timer_post_reset", bus.sram_rdata, 32'h0000_0002);
        access(1'b1, 4'h0, 32'h0000_0014, 32'h0);
        check32("ram_kept_over_reset", bus.sram_rdata, 32'hCAFE_F00D);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sram_resp.md
SRAM_RESP -- requirements
Module: sram_resp

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 12, meaning log2 of the number of 32-bit RAM words.
REQ-002 The module SHALL have parameter MMIO_HI, default 16'hBFAF, meaning addr[31:16] value that selects the MMIO region.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The module SHALL have port sram_en, input, 1 bit: access request this cycle.
REQ-006 The module SHALL have port sram_wen, input, 4 bits: byte-lane write enables; 4'b0000 with sram_en means read.
REQ-007 The module SHALL have port sram_addr, input, 32 bits: byte address; bits [1:0] ignored.
REQ-008 The module SHALL have port sram_wdata, input, 32 bits: write data; lane i is bits [8i+7:8i].
REQ-009 The module SHALL have port sram_rdata, output, 32 bits: read data.
REQ-010 The module SHALL have port led, output, 16 bits: current LED register value.

Function
REQ-011 Decode: addr[31:16]==MMIO_HI SHALL select MMIO; every other address SHALL select RAM word addr[ADDR_W+1:2] (upper bits ignored, wrap-around modulo depth).
REQ-012 A read (sram_en=1, sram_wen=0) accepted at edge N SHALL drive sram_rdata with the addressed word from edge N until the next accepted read; latency is exactly one cycle.
REQ-013 sram_rdata SHALL hold its value in every cycle without a read, including write cycles and sram_en=0 cycles.
REQ-014 A write SHALL update only the lanes whose sram_wen bit is 1; other lanes keep their value.
REQ-015 Back-to-back write then read of the same word SHALL return the newly written data (write visible at the edge it is accepted).
REQ-016 MMIO map (offset = addr[15:0]): 0x0000 LED (RW, bits [15:0], upper read 0); 0x0004 TIMER (RW, 32 bits); 0x0008 SCRATCH (RW, 32 bits); every other offset SHALL read 0 and ignore writes.
REQ-017 TIMER SHALL increment by 1 every cycle and wrap from 32'hFFFFFFFF to 0.
REQ-018 A TIMER write SHALL load the lane-merged value (written lanes from sram_wdata, other lanes from the current value) and take precedence over the increment in that cycle.
REQ-019 A TIMER read accepted at edge N SHALL return the value TIMER held just before edge N.
REQ-020 The led output SHALL equal the LED register bits [15:0] at all times.
REQ-021 When sram_en=0, sram_wen, sram_addr and sram_wdata SHALL be ignored; no state except TIMER changes.

Reset
REQ-022 While rst=1, sram_rdata, LED, TIMER and SCRATCH SHALL be 0, independent of clk.
REQ-023 RAM contents SHALL NOT be reset; reads of never-written words return unspecified data.
REQ-024 A request presented in the same cycle that rst deasserts SHALL NOT be accepted; the first accepted access is at the first rising edge with rst=0.
REQ-025 Reset asserted mid-operation SHALL discard any pending read result; sram_rdata reads 0 until the next accepted read.

Structure
REQ-026 MMIO_HI default, MMIO offsets (LED, TIMER, SCRATCH) and lane-merge width SHALL be defined as constants in the shared defines header.
REQ-027 The byte-enable RAM array SHALL be a sub-module sram_bank (ports: clk, we[3:0], idx, wdata, rdata), synchronous write, combinational read.
REQ-028 The output read register, MMIO registers and decode SHALL reside in sram_resp.

Verification
REQ-029 Write addr 0x0000_0010, wen 4'b1111, wdata 0x12345678, then read the same addr -> sram_rdata 0x12345678 one cycle after the read.
REQ-030 Write 0x0000_0010, wen 4'b0010, wdata 0xAABBCCDD over 0x12345678 -> read returns 0x1234CC78.
REQ-031 With ADDR_W=12, write 0x0000_4000 with data 0x55 -> read 0x0000_0000 returns 0x55 (wrap-around).
REQ-032 Write LED 0xBFAF_0000 wdata 0xFFFF_A5A5 -> led=16'hA5A5; read returns 0x0000A5A5; read 0xBFAF_00F0 returns 0.
REQ-033 Write TIMER wen 4'b1111 wdata 0xFFFF_FFFE; idle 1 cycle; read -> 0xFFFFFFFF; next read one cycle later -> 0x00000000.
REQ-034 Read SCRATCH returning 0xDEADBEEF, assert rst for 1 cycle mid-idle -> sram_rdata, led, SCRATCH read back all 0.
